// File: rtl/partial_sum_sequencer.sv
// partial_sum_sequencer
//   Sequences one vector job through a partial-matrix accumulator: accepts a
//   start request with a tile count, passes that many partial-product tiles
//   straight through to the accumulator (flagging the final one), waits for
//   the accumulated result vector, registers it and presents it downstream.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   start, cfg_num_tiles job request and tile count (sampled on accept in IDLE)
//   s_tile_*             upstream tile stream (valid/ready/data)
//   m_acc_*, acc_ready   tile stream into the accumulator (valid/last/data)
//   acc_result_*         result from the accumulator (valid/data/ready)
//   m_res_*              downstream result handshake (valid/ready/data)
//   busy                 high in every state except IDLE
//   done, err_cfg,       single-cycle status pulses
//   err_timeout
module partial_sum_sequencer #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned M_SIZE  = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            start,
  input  logic [CNT_W-1:0]                cfg_num_tiles,
  input  logic                            s_tile_valid,
  output logic                            s_tile_ready,
  input  logic [D_WIDTH*M_SIZE*M_SIZE-1:0] s_tile_data,
  output logic                            m_acc_valid,
  output logic                            m_acc_last,
  output logic [D_WIDTH*M_SIZE*M_SIZE-1:0] m_acc_data,
  input  logic                            acc_ready,
  input  logic                            acc_result_valid,
  input  logic [D_WIDTH*M_SIZE-1:0]       acc_result,
  output logic                            acc_result_ready,
  output logic                            m_res_valid,
  input  logic                            m_res_ready,
  output logic [D_WIDTH*M_SIZE-1:0]       m_res_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err_cfg,
  output logic                            err_timeout
);

  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Value of the wait counter during the final permitted WAIT_RES cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FEED     = 2'd1,
    WAIT_RES = 2'd2,
    OUTPUT   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tile_cnt;
  logic [CNT_W-1:0]  num_tiles;
  logic [TO_W-1:0]   to_cnt;
  logic              in_feed;
  logic              xfer;
  logic              last_tile;

  assign in_feed   = (state == FEED);
  // num_tiles is never zero while in FEED, so the subtraction cannot wrap there.
  assign last_tile = (tile_cnt == (num_tiles - CNT_W'(1)));
  assign xfer      = in_feed && s_tile_valid && acc_ready;

  // Tile path is a pure pass-through while feeding; quiet otherwise.
  assign m_acc_valid  = in_feed && s_tile_valid;
  assign s_tile_ready = in_feed && acc_ready;
  assign m_acc_last   = in_feed && last_tile;
  assign m_acc_data   = in_feed ? s_tile_data : '0;

  // Decoded straight from the state register, so these drop to 0 the instant
  // reset forces IDLE.
  assign acc_result_ready = (state == WAIT_RES);
  assign m_res_valid      = (state == OUTPUT);
  assign busy             = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      tile_cnt    <= '0;
      num_tiles   <= '0;
      to_cnt      <= '0;
      m_res_data  <= '0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_num_tiles != '0) begin
              num_tiles <= cfg_num_tiles;
              tile_cnt  <= '0;
              state     <= FEED;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        FEED: begin
          if (xfer) begin
            tile_cnt <= tile_cnt + CNT_W'(1);
            if (last_tile) begin
              to_cnt <= '0;
              state  <= WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          // A result arriving in the final permitted cycle still wins.
          if (acc_result_valid) begin
            m_res_data <= acc_result;
            state      <= OUTPUT;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        OUTPUT: begin
          if (m_res_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_partial_sum_sequencer.sv
// Testbench for partial_sum_sequencer (D_WIDTH=32, M_SIZE=2, TIMEOUT=8).
// The bench plays the upstream tile source, the accumulator and the
// downstream result sink.
module tb_partial_sum_sequencer;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_num_tiles = '0;
  logic          s_tile_valid = 1'b0;
  logic          s_tile_ready;
  logic [127:0]  s_tile_data = '0;
  logic          m_acc_valid;
  logic          m_acc_last;
  logic [127:0]  m_acc_data;
  logic          acc_ready = 1'b0;
  logic          acc_result_valid = 1'b0;
  logic [63:0]   acc_result = '0;
  logic          acc_result_ready;
  logic          m_res_valid;
  logic          m_res_ready = 1'b0;
  logic [63:0]   m_res_data;
  logic          busy, done, err_cfg, err_timeout;

  int unsigned passed = 0;
  int unsigned total  = 0;

  partial_sum_sequencer #(
    .D_WIDTH (32),
    .M_SIZE  (2),
    .CNT_W   (8),
    .TIMEOUT (8)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .cfg_num_tiles    (cfg_num_tiles),
    .s_tile_valid     (s_tile_valid),
    .s_tile_ready     (s_tile_ready),
    .s_tile_data      (s_tile_data),
    .m_acc_valid      (m_acc_valid),
    .m_acc_last       (m_acc_last),
    .m_acc_data       (m_acc_data),
    .acc_ready        (acc_ready),
    .acc_result_valid (acc_result_valid),
    .acc_result       (acc_result),
    .acc_result_ready (acc_result_ready),
    .m_res_valid      (m_res_valid),
    .m_res_ready      (m_res_ready),
    .m_res_data       (m_res_data),
    .busy             (busy),
    .done             (done),
    .err_cfg          (err_cfg),
    .err_timeout      (err_timeout)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int unsigned  tiles;    // cfg_num_tiles
    bit           toggle;   // acc_ready low/high alternating during FEED
    int unsigned  hold;     // cycles m_res_ready stays low in OUTPUT
    logic [127:0] tile0;    // first tile; later tiles are tile0 + index
    logic [63:0]  res;      // accumulator reply == expected m_res_data
    int unsigned  exp_lat;  // expected start-to-m_res_valid edges, 0 = skip
  } job_t;

  job_t jobs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [8:0] ctl_outs();
    return {busy, done, err_cfg, err_timeout, m_acc_valid, m_acc_last,
            s_tile_ready, acc_result_ready, m_res_valid};
  endfunction

  task automatic run_job(input job_t j);
    int unsigned  xfers = 0;
    int unsigned  edges = 0;
    int unsigned  cyc   = 0;
    int unsigned  lasts = 0;
    bit           rdy;
    logic [127:0] d;
    start = 1'b1;
    cfg_num_tiles = 8'(j.tiles);
    step();
    start = 1'b0;
    edges = 1;
    check("busy_after_start", busy, 1'b1);
    while (xfers < j.tiles && cyc < 100) begin
      rdy = j.toggle ? (cyc % 2 == 1) : 1'b1;
      d   = j.tile0 + 128'(xfers);
      acc_ready    = rdy;
      s_tile_valid = 1'b1;
      s_tile_data  = d;
      #1;
      check("feed_s_tile_ready", s_tile_ready, rdy);
      check("feed_m_acc_valid", m_acc_valid, 1'b1);
      check("feed_m_acc_data", m_acc_data, d);
      check("feed_m_acc_last", m_acc_last, (xfers == j.tiles - 1));
      if (rdy) begin
        if (m_acc_last) lasts++;
        xfers++;
      end
      step();
      edges++;
      cyc++;
    end
    check("feed_transfers", xfers, j.tiles);
    check("feed_last_count", lasts, 1);
    s_tile_valid     = 1'b0;
    acc_ready        = 1'b1;
    acc_result_valid = 1'b1;
    acc_result       = j.res;
    #1;
    check("wait_acc_result_ready", acc_result_ready, 1'b1);
    check("wait_tile_path_quiet", {m_acc_valid, m_acc_last, s_tile_ready}, 3'b000);
    step();
    edges++;
    acc_result_valid = 1'b0;
    acc_ready        = 1'b0;
    check("out_m_res_valid", m_res_valid, 1'b1);
    check("out_m_res_data", m_res_data, j.res);
    check("out_acc_result_ready_low", acc_result_ready, 1'b0);
    if (j.exp_lat != 0) check("latency_edges", edges, j.exp_lat);
    for (int unsigned h = 0; h < j.hold; h++) begin
      step();
      check("hold_m_res_valid", m_res_valid, 1'b1);
      check("hold_m_res_data", m_res_data, j.res);
      check("hold_no_done", done, 1'b0);
    end
    m_res_ready = 1'b1;
    step();
    m_res_ready = 1'b0;
    check("done_pulse", {done, busy, m_res_valid}, 3'b100);
    step();
    check("done_cleared", {done, busy}, 2'b00);
  endtask

  initial begin
    int unsigned wc;

    jobs[0] = '{tiles: 1, toggle: 1'b0, hold: 0,
                tile0: 128'h3F800000_40000000_40800000_41000000,
                res: 64'h40400000_41400000, exp_lat: 3};
    jobs[1] = '{tiles: 4, toggle: 1'b1, hold: 0,
                tile0: 128'h00000001_00000002_00000003_00000100,
                res: 64'hAAAA5555_0F0F0F0F, exp_lat: 0};
    jobs[2] = '{tiles: 3, toggle: 1'b0, hold: 5,
                tile0: 128'hDEADBEEF_CAFEF00D_01234567_89ABCDE0,
                res: 64'h12345678_9ABCDEF0, exp_lat: 5};
    jobs[3] = '{tiles: 2, toggle: 1'b0, hold: 1,
                tile0: 128'h40000000_40000000_40000000_40000000,
                res: 64'h40800000_40800000, exp_lat: 4};

    // Reset state, with inputs that would otherwise make outputs toggle.
    acc_ready = 1'b1;
    s_tile_valid = 1'b1;
    #3;
    check("reset_ctl_outs", ctl_outs(), 9'd0);
    check("reset_m_res_data", m_res_data, 64'd0);
    check("reset_m_acc_data", m_acc_data, 128'd0);
    acc_ready = 1'b0;
    s_tile_valid = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    step();
    check("idle_after_reset", ctl_outs(), 9'd0);

    // Table-driven jobs.
    for (int unsigned k = 0; k < 4; k++) run_job(jobs[k]);

    // Zero tile count: err_cfg pulse, stays idle, tile path closed.
    acc_ready = 1'b1;
    start = 1'b1;
    cfg_num_tiles = 8'd0;
    step();
    start = 1'b0;
    check("err_cfg_pulse", {err_cfg, busy, s_tile_ready}, 3'b100);
    step();
    check("err_cfg_cleared", {err_cfg, busy}, 2'b00);
    acc_ready = 1'b0;

    // Timeout: one tile, accumulator silent; a stray start mid-wait is ignored.
    start = 1'b1;
    cfg_num_tiles = 8'd1;
    step();
    start = 1'b0;
    s_tile_valid = 1'b1;
    acc_ready = 1'b1;
    s_tile_data = 128'h5;
    step();
    s_tile_valid = 1'b0;
    acc_ready = 1'b0;
    wc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!acc_result_ready) break;
      wc++;
      check("timeout_no_early_err", err_timeout, 1'b0);
      start = (wc == 3);
      cfg_num_tiles = 8'd5;
      step();
    end
    start = 1'b0;
    check("timeout_wait_cycles", wc, 8);
    check("timeout_pulse", {err_timeout, busy}, 2'b10);
    check("timeout_res_unchanged", m_res_data, jobs[3].res);
    step();
    check("timeout_cleared", {err_timeout, busy, done}, 3'b000);

    // Reset after 2 of 4 tiles, then a clean job.
    start = 1'b1;
    cfg_num_tiles = 8'd4;
    step();
    start = 1'b0;
    s_tile_valid = 1'b1;
    acc_ready = 1'b1;
    s_tile_data = 128'h77;
    step();
    step();
    check("midjob_still_feeding", {busy, m_acc_valid}, 2'b11);
    aresetn = 1'b0;
    #1;
    check("midjob_reset_ctl", ctl_outs(), 9'd0);
    check("midjob_reset_res", m_res_data, 64'd0);
    check("midjob_reset_acc_data", m_acc_data, 128'd0);
    s_tile_valid = 1'b0;
    acc_ready = 1'b0;
    step();
    aresetn = 1'b1;
    wc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || err_cfg || err_timeout || busy) wc++;
    end
    check("post_reset_quiet_cycles", wc, 0);
    run_job(jobs[2]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/partial_sum_sequencer.md
PARTIAL_SUM_SEQUENCER -- requirements
Module: partial_sum_sequencer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, bit width of one IEEE-754 single-precision element.
REQ-002 SHALL have parameter M_SIZE, default 2, matrix/vector dimension.
REQ-003 SHALL have parameter CNT_W, default 8, width of the tile counter and cfg_num_tiles.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles spent in WAIT_RES.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to begin one vector job.
REQ-008 cfg_num_tiles  in  CNT_W  number of partial matrices in the job; sampled only when start is accepted.
REQ-009 s_tile_valid / s_tile_ready  in / out  1  upstream tile handshake.
REQ-010 s_tile_data  in  D_WIDTH*M_SIZE*M_SIZE  upstream partial-product matrix.
REQ-011 m_acc_valid / m_acc_last  out  1  drive the accumulator's partial-matrix valid and last inputs.
REQ-012 m_acc_data  out  D_WIDTH*M_SIZE*M_SIZE  matrix to the accumulator.
REQ-013 acc_ready  in  1  accumulator ready-for-data.
REQ-014 acc_result_valid  in  1  accumulator result valid.
REQ-015 acc_result  in  D_WIDTH*M_SIZE  accumulator result vector.
REQ-016 acc_result_ready  out  1  drives the accumulator's receiver-ready input.
REQ-017 m_res_valid / m_res_ready  out / in  1  downstream result handshake.
REQ-018 m_res_data  out  D_WIDTH*M_SIZE  registered result vector.
REQ-019 busy, done, err_cfg, err_timeout  out  1 each  status; done and the err outputs are single-cycle pulses.

Function
REQ-020 The FSM SHALL have four states: IDLE, FEED, WAIT_RES, OUTPUT.
REQ-021 IDLE: start=1 with cfg_num_tiles!=0 SHALL latch num_tiles, clear tile_cnt, and go to FEED on the next edge.
REQ-022 IDLE: start=1 with cfg_num_tiles==0 SHALL pulse err_cfg for one cycle and remain in IDLE.
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 FEED: the path SHALL be combinational pass-through: m_acc_valid=s_tile_valid, s_tile_ready=acc_ready, m_acc_data=s_tile_data.
REQ-025 FEED: a transfer occurs when s_tile_valid and acc_ready are both high; tile_cnt SHALL increment by 1 per transfer.
REQ-026 m_acc_last SHALL be 1 in FEED exactly when tile_cnt==num_tiles-1.
REQ-027 The transfer with m_acc_last=1 SHALL move the FSM to WAIT_RES and clear the timeout counter.
REQ-028 Outside FEED, m_acc_valid, m_acc_last and s_tile_ready SHALL be 0.
REQ-029 WAIT_RES: acc_result_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-030 WAIT_RES: on acc_result_valid=1, acc_result SHALL be registered into m_res_data and the FSM SHALL go to OUTPUT.
REQ-031 WAIT_RES: the timeout counter SHALL increment each cycle.
REQ-032 On reaching TIMEOUT without acc_result_valid, the block SHALL pulse err_timeout and return to IDLE, leaving m_res_data unchanged.
REQ-033 OUTPUT: m_res_valid SHALL be 1 and m_res_data SHALL be held stable until m_res_ready=1.
REQ-034 On the m_res_ready handshake the block SHALL pulse done for one cycle (registered, in the cycle after the handshake) and return to IDLE.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 Minimum job latency, start to m_res_valid, SHALL be num_tiles + 2 cycles with zero stalls and the accumulator result arriving one cycle after last.

Reset
REQ-037 While aresetn=0, the FSM SHALL be in IDLE.
REQ-038 While aresetn=0, tile_cnt, num_tiles, the timeout counter and m_res_data SHALL be 0.
REQ-039 While aresetn=0, all status and handshake outputs (busy, done, err_cfg, err_timeout, m_acc_valid, m_acc_last, s_tile_ready, acc_result_ready, m_res_valid) SHALL be 0.
REQ-040 Reset asserted mid-job SHALL abort the job immediately; no done or err pulse SHALL follow release.

Verification
REQ-041 cfg_num_tiles=1; tile {0x3F800000, 0x40000000, 0x40800000, 0x41000000}; accumulator model returns {0x40400000, 0x41400000} -> one m_acc_valid with m_acc_last=1, m_res_data={0x40400000, 0x41400000}, done pulse.
REQ-042 cfg_num_tiles=4, acc_ready toggling every other cycle -> exactly 4 transfers, last only on the 4th, s_tile_ready tracks acc_ready.
REQ-043 Result ready, m_res_ready held low for 5 cycles -> m_res_valid and m_res_data stable for 5 cycles; done only after the handshake.
REQ-044 cfg_num_tiles=0 with start -> err_cfg for 1 cycle, busy stays 0.
REQ-045 TIMEOUT=8, accumulator never responds -> err_timeout on the 8th WAIT_RES cycle, then IDLE, busy=0.
REQ-046 aresetn pulsed low after 2 of 4 tiles -> all outputs 0 immediately; a new job then completes normally.
